hdmi_video_timing: RTL

Parametrised video timing and test-pattern generator for the ADV7513 HDMI transmitter parallel interface. It is the next generation of `hdmi_generator`. It adds:
- elaboration-time resolution and sync polarity;
- pixel coordinates and frame/line markers;
- a run-time enable;
- a frame-synchronous test-pattern selector driving 24-bit RGB.

It runs in the PLL pixel-clock domain and drives HDMI_TX_HS/VS/DE/D directly.

---
 rtl/hdmi_timing_pkg.sv | 21 ++
 rtl/hdmi_video_timing_pattern.sv | 37 +++
 rtl/hdmi_video_timing.sv | 111 +++++++++++
 3 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared constants for the HDMI video timing generator: pattern codes,
// colour-bar palette and RGB width.
package hdmi_timing_pkg;

  localparam int unsigned RGB_W = 24;

  typedef enum logic [2:0] {
    PAT_BLACK   = 3'd0,
    PAT_BARS    = 3'd1,
    PAT_CHECKER = 3'd2,
    PAT_RAMP    = 3'd3,
    PAT_WHITE   = 3'd4
  } pattern_e;

  // Left-to-right order of the eight colour bars.
  localparam logic [RGB_W-1:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/hdmi_video_timing_pattern.sv
// Combinational test-pattern mapper: (pattern, x, y, de) -> 24-bit RGB.
module hdmi_pattern_gen
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned CW       = 12
) (
  input  logic [2:0]       pattern,
  input  logic [CW-1:0]    x,
  input  logic [CW-1:0]    y,
  input  logic             de,
  output logic [RGB_W-1:0] rgb
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic       unused_y_bits;

  assign bar_idx       = 3'(x / CW'(BAR_W));
  assign unused_y_bits = ^y;

  always_comb begin
    rgb = '0;
    if (de) begin
      case (pattern)
        PAT_BLACK:   rgb = '0;
        PAT_BARS:    rgb = BAR_RGB[bar_idx];
        PAT_CHECKER: rgb = (x[5] ^ y[5]) ? '1 : '0;
        PAT_RAMP:    rgb = {3{x[7:0]}};
        PAT_WHITE:   rgb = '1;
        default:     rgb = '0;
      endcase
    end
  end

endmodule

// File: rtl/hdmi_video_timing.sv
// Video timing generator for the ADV7513 parallel interface: counters, sync
// decode, frame-synchronous pattern latch and registered outputs.
module hdmi_video_timing
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 62,
  parameter int unsigned H_BP     = 60,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 9,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 30,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CW       = 12
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic [2:0]       i_pattern,
  output logic             o_hdmi_hs,
  output logic             o_hdmi_vs,
  output logic             o_hdmi_de,
  output logic [RGB_W-1:0] o_hdmi_rgb,
  output logic [CW-1:0]    o_x,
  output logic [CW-1:0]    o_y,
  output logic             o_frame_start,
  output logic             o_line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE % 8 != 0) begin : g_h_active_check
    $error("H_ACTIVE must be a multiple of 8");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_check
    $error("CW too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

  logic [CW-1:0]    h_cnt;
  logic [CW-1:0]    v_cnt;
  logic [2:0]       active_pattern;
  logic             de_c;
  logic             hs_act;
  logic             vs_act;
  logic [RGB_W-1:0] rgb_c;

  assign de_c   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  hdmi_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .CW       (CW)
  ) u_pattern (
    .pattern (active_pattern),
    .x       (h_cnt),
    .y       (v_cnt),
    .de      (de_c),
    .rgb     (rgb_c)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_enable) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      o_hdmi_hs     <= ~HS_POL;
      o_hdmi_vs     <= ~VS_POL;
      o_hdmi_de     <= 1'b0;
      o_hdmi_rgb    <= '0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
      // Disable only idles the raster; the selected pattern survives it.
      if (!i_reset_n) active_pattern <= '0;
    end else begin
      o_hdmi_hs     <= hs_act ? HS_POL : ~HS_POL;
      o_hdmi_vs     <= vs_act ? VS_POL : ~VS_POL;
      o_hdmi_de     <= de_c;
      o_hdmi_rgb    <= rgb_c;
      o_x           <= de_c ? h_cnt : '0;
      o_y           <= de_c ? v_cnt : '0;
      o_frame_start <= de_c && (h_cnt == '0) && (v_cnt == '0);
      o_line_start  <= de_c && (h_cnt == '0);
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt          <= '0;
          active_pattern <= i_pattern;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule
